// File: rtl/fm_ram_ctrl.sv
// Bus-side controller for the 16 KB FM/OPL RAM: turns multi-cycle CPU strobes into
// single-cycle RAM accesses, with a write-enable register guarding the preloaded image.
module fm_ram_ctrl #(
    parameter logic [15:0] WINDOW_BASE = 16'h4000,
    parameter logic [15:0] CTRL_ADDR   = 16'h7FF6,
    parameter logic        WE_RESET    = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        busy,
    output logic [13:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_wren,
    input  logic [7:0]  ram_q
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        RD_HOLD,
        WR_HOLD
    } state_t;

    typedef enum logic [1:0] {
        SRC_RAM,
        SRC_CTRL,
        SRC_NONE
    } src_t;

    state_t state;
    src_t   rd_src;
    logic   rd_q;
    logic   wr_q;
    logic   ctrl_we;

    logic   cs_rd;
    logic   cs_wr;
    logic   rd_start;
    logic   wr_start;
    logic   in_window;
    logic   is_ctrl;

    // Starts need a fresh strobe edge; simultaneous rd and wr start nothing.
    always_comb begin
        cs_rd     = cs & rd;
        cs_wr     = cs & wr;
        rd_start  = (state == IDLE) & cs_rd & ~rd_q & ~wr;
        wr_start  = (state == IDLE) & cs_wr & ~wr_q & ~rd;
        in_window = (addr[15:14] == WINDOW_BASE[15:14]);
        is_ctrl   = (addr == CTRL_ADDR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rd_src      <= SRC_NONE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            ctrl_we     <= WE_RESET;
            dout        <= 8'hFF;
            dout_valid  <= 1'b0;
            busy        <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
        end else begin
            rd_q     <= cs_rd;
            wr_q     <= cs_wr;
            ram_wren <= 1'b0;

            case (state)
                IDLE: begin
                    if (rd_start) begin
                        ram_address <= addr[13:0];
                        if (is_ctrl)
                            rd_src <= SRC_CTRL;
                        else if (in_window)
                            rd_src <= SRC_RAM;
                        else
                            rd_src <= SRC_NONE;
                        dout_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RD_ADDR;
                    end else if (wr_start) begin
                        state <= WR_HOLD;
                        // The enable used here is the one in force before this edge.
                        if (is_ctrl) begin
                            ctrl_we <= din[0];
                        end else if (in_window && ctrl_we) begin
                            ram_address <= addr[13:0];
                            ram_data    <= din;
                            ram_wren    <= 1'b1;
                        end
                    end
                end

                RD_ADDR: state <= RD_DATA;

                RD_DATA: begin
                    case (rd_src)
                        SRC_RAM:  dout <= ram_q;
                        SRC_CTRL: dout <= {7'h00, ctrl_we};
                        default:  dout <= 8'hFF;
                    endcase
                    dout_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= RD_HOLD;
                end

                RD_HOLD: begin
                    if (!cs_rd) begin
                        dout_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end

                WR_HOLD: begin
                    if (!cs_wr)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fm_ram_ctrl.md
Name: fm_ram_ctrl

Overview:
- Bus-side controller that sits directly upstream of the 16 KB FM/OPL RAM (`ram_16kb`: 14-bit address, 1-cycle registered read).
- Converts multi-cycle CPU memory strobes into single-cycle RAM accesses.
- Maps a 16 KB CPU window onto the RAM and provides a write-enable control register that protects the preloaded image.
- Latches read data and holds it stable for the CPU until the strobe ends.

Parameters:
- WINDOW_BASE, 16'h4000, CPU base address of the 16 KB window; bits [13:0] must be zero.
- CTRL_ADDR, 16'h7FF6, CPU address of the control register; must lie inside the window.
- WE_RESET, 1'b0, reset value of the RAM write-enable bit.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  slot/page select from the bus decoder.
- rd  in  1  CPU read strobe, active high, held for multiple clocks.
- wr  in  1  CPU write strobe, active high, held for multiple clocks.
- addr  in  16  CPU address; sampled only on the access-start edge.
- din  in  8  CPU write data; sampled only on the access-start edge.
- dout  out  8  read data to the CPU.
- dout_valid  out  1  dout holds the result of the current read.
- busy  out  1  access in progress; drives CPU wait.
- ram_address  out  14  to RAM `address`.
- ram_data  out  8  to RAM `data`.
- ram_wren  out  1  to RAM `wren`.
- ram_q  in  8  from RAM `q`; valid one clock after the address is registered.

Behaviour:
- Reset state:
  - Reset is synchronous and active-high; it wins over every other event.
  - State=IDLE, dout=8'hFF, dout_valid=0, busy=0.
  - ram_address=0, ram_data=0, ram_wren=0, ctrl_we=WE_RESET.
  - rd_q=0 and wr_q=0, where rd_q/wr_q are the previous-cycle values of cs&rd and cs&wr.
- Start condition:
  - Read start: cs&rd=1, rd_q=0, wr=0, in IDLE.
  - Write start: cs&wr=1, wr_q=0, rd=0, in IDLE.
  - rd and wr both high: no access, state stays IDLE.
  - A strobe edge occurring outside IDLE is ignored; an access starts only from a fresh edge while in IDLE.
- In-window test: addr[15:14]==WINDOW_BASE[15:14].
- States: IDLE, RD_ADDR, RD_DATA, RD_HOLD, WR_HOLD.
- Read path:
  - E0 (start edge): ram_address<=addr[13:0]; record whether the access is to the register, out of window, or RAM; dout_valid<=0; go RD_ADDR; busy=1.
  - E1: the RAM samples the address. RD_ADDR->RD_DATA.
  - E2: dout<=ram_q for an in-window non-register address; {7'h0,ctrl_we} for CTRL_ADDR; 8'hFF out of window. dout_valid<=1, busy<=0, go RD_HOLD.
  - Latency: start edge to dout_valid is 2 clocks, fixed for all three cases.
  - RD_HOLD: dout stays frozen until cs&rd=0; then go IDLE with dout_valid<=0. dout keeps its last value.
  - rd dropping during RD_ADDR/RD_DATA: the sequence still completes; the next edge then sees rd low, so it goes straight RD_HOLD->IDLE.
- Write path:
  - E0 (start edge): go WR_HOLD; busy stays 0.
  - CTRL_ADDR: ctrl_we<=din[0]; no RAM write.
  - In-window and ctrl_we=1: ram_address<=addr[13:0], ram_data<=din, ram_wren<=1 for exactly one clock. ctrl_we is the value before this edge.
  - In-window and ctrl_we=0, or out of window: write dropped silently; ram_wren stays 0.
  - WR_HOLD -> IDLE when cs&wr=0.
- ram_wren: never high for more than one consecutive cycle, and never high in any read state.
- Reset mid-operation: return to IDLE on the next edge. A pending read's result is discarded (dout=8'hFF, dout_valid=0). ram_wren is forced 0 even if a write was issued on the same edge.
- Width: ram_address is always addr[13:0]; there is no banking and no wrap arithmetic. Address 0x7FFF maps to 14'h3FFF.

Test Plan:
1. Reset, then read 0x4000 with RAM word 0 = 8'h5A: ram_address=0 one clock after the edge; dout=8'h5A with dout_valid=1 exactly 2 clocks after the edge; busy high for those 2 clocks; dout held until rd drops.
2. Write 8'hC3 to 0x4123 with ctrl_we=0: ram_wren never asserts; a following read of 0x4123 returns the original content.
3. Write 8'h01 to 0x7FF6, then write 8'hC3 to 0x4123: exactly one ram_wren pulse with ram_address=14'h0123 and ram_data=8'hC3; a read-back returns 8'hC3; a read of 0x7FF6 returns 8'h01.
4. Read 0x8000 with cs=1: dout=8'hFF after 2 clocks; held write strobe (wr high 6 clocks) to an enabled address: exactly one ram_wren pulse.
5. rd and wr asserted together: no state change, no ram_wren, busy=0.
6. Reset asserted in RD_DATA: next edge gives IDLE, dout=8'hFF, dout_valid=0, ctrl_we=WE_RESET; reset asserted on a write-start edge: no ram_wren.
